// File: rtl/dct_idct_seq.sv
`default_nettype none
// ============================================================================
// Module  : dct_idct_seq
// Brief   : Frame sequencer feeding pixels to a DCT, chaining it to an IDCT
//           and collecting reconstructed pixels, with underflow/drain checks.
// Revision: 1.0
// ============================================================================
module dct_idct_seq #(
  parameter int BitWidth    = 31,
  parameter int BLK_SAMPLES = 64,
  parameter int TIMEOUT     = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [15:0]       num_blocks,
  input  logic              src_valid,
  input  logic [BitWidth:0] src_data,
  output logic              src_ready,
  output logic              dct_start,
  output logic [BitWidth:0] dct_din,
  input  logic              dct_reading,
  input  logic              dct_done,
  input  logic [BitWidth:0] dct_dout,
  output logic              idct_start,
  output logic [BitWidth:0] idct_din,
  input  logic              idct_done,
  input  logic [BitWidth:0] idct_dout,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err_underflow,
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [31:0] c_blk     = 32'(BLK_SAMPLES);
  localparam logic [31:0] c_timeout = 32'(TIMEOUT);

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_num_blocks;
  logic [31:0]       r_in_cnt;
  logic [31:0]       r_out_cnt;
  logic [31:0]       r_win_cnt;
  logic [31:0]       r_wd;
  logic [BitWidth:0] r_dct_din;
  logic              r_err_uf;
  logic              r_err_to;
  logic              r_zero_done;

  logic [31:0] w_target;
  logic [31:0] w_in_nxt;
  logic [31:0] w_out_nxt;
  logic [31:0] w_wd_nxt;
  logic        w_accept;
  logic        w_out_valid;
  logic        w_in_hit;
  logic        w_out_hit;
  logic        w_wd_hit;
  logic        w_frame_go;
  logic        w_unused;

  assign w_target    = {16'd0, r_num_blocks} * c_blk;
  assign src_ready   = (r_state == FEED) && dct_reading;
  assign w_accept    = src_ready && src_valid;
  // Gated by reset so a live idct window cannot leak out while held in reset.
  assign w_out_valid = reset && idct_done && (r_win_cnt < c_blk);
  assign w_in_nxt    = r_in_cnt + {31'd0, w_accept};
  assign w_out_nxt   = r_out_cnt + {31'd0, w_out_valid && (r_state != IDLE)};
  assign w_wd_nxt    = w_out_valid ? 32'd0 : r_wd + 32'd1;
  assign w_in_hit    = (w_in_nxt >= w_target);
  assign w_out_hit   = (w_out_nxt >= w_target);
  assign w_wd_hit    = (w_wd_nxt >= c_timeout);
  assign w_frame_go  = frame_start && (num_blocks != 16'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_frame_go) w_next = FEED;
      FEED:    if (w_in_hit) w_next = DRAIN;
      DRAIN:   if (w_out_hit || w_wd_hit) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_num_blocks <= 16'd0;
      r_in_cnt     <= 32'd0;
      r_out_cnt    <= 32'd0;
      r_win_cnt    <= 32'd0;
      r_wd         <= 32'd0;
      r_dct_din    <= '0;
      r_err_uf     <= 1'b0;
      r_err_to     <= 1'b0;
      r_zero_done  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_cnt    <= w_in_nxt;
      r_out_cnt   <= w_out_nxt;
      r_wd        <= (r_state == DRAIN) ? w_wd_nxt : 32'd0;
      r_zero_done <= (r_state == IDLE) && frame_start && (num_blocks == 16'd0);
      if (w_accept) r_dct_din <= src_data;
      if (!idct_done)
        r_win_cnt <= 32'd0;
      else if (r_win_cnt < c_blk)
        r_win_cnt <= r_win_cnt + 32'd1;
      if ((r_state == IDLE) && w_frame_go) begin
        r_num_blocks <= num_blocks;
        r_in_cnt     <= 32'd0;
        r_out_cnt    <= 32'd0;
        r_err_uf     <= 1'b0;
        r_err_to     <= 1'b0;
      end
      if ((r_state == FEED) && dct_reading && !src_valid) r_err_uf <= 1'b1;
      // Completion on the same cycle as expiry is not a timeout.
      if ((r_state == DRAIN) && w_wd_hit && !w_out_hit) r_err_to <= 1'b1;
    end
  end

  assign dct_start     = (r_state == FEED);
  assign dct_din       = r_dct_din;
  assign idct_start    = dct_done;
  assign idct_din      = {{18{dct_dout[BitWidth]}}, dct_dout[BitWidth:18]};
  assign out_valid     = w_out_valid;
  assign out_data      = idct_dout[17:10];
  assign busy          = (r_state != IDLE);
  assign frame_done    = r_zero_done || (r_state == FIN);
  assign err_underflow = r_err_uf;
  assign err_timeout   = r_err_to;

  assign w_unused = ^{dct_dout[17:0], idct_dout[BitWidth:18], idct_dout[9:0]};

endmodule
`default_nettype wire

// File: tb/tb_dct_idct_seq.sv
`default_nettype none
// Self-checking bench for dct_idct_seq: vector table for the datapath slices
// plus randomized frames compared against a sample-counting reference model.
module tb_dct_idct_seq;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic [15:0] num_blocks;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready;
  logic        dct_start;
  logic [31:0] dct_din;
  logic        dct_reading;
  logic        dct_done;
  logic [31:0] dct_dout;
  logic        idct_start;
  logic [31:0] idct_din;
  logic        idct_done;
  logic [31:0] idct_dout;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        busy;
  logic        frame_done;
  logic        err_underflow;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_din;
  logic        m_uf;

  typedef struct {
    logic [31:0] dd;
    logic [31:0] id;
    logic [31:0] exp_din;
    logic [7:0]  exp_od;
  } vec_t;
  vec_t tbl[6];

  dct_idct_seq dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .num_blocks(num_blocks),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .dct_start(dct_start), .dct_din(dct_din), .dct_reading(dct_reading),
    .dct_done(dct_done), .dct_dout(dct_dout), .idct_start(idct_start),
    .idct_din(idct_din), .idct_done(idct_done), .idct_dout(idct_dout),
    .out_valid(out_valid), .out_data(out_data), .busy(busy),
    .frame_done(frame_done), .err_underflow(err_underflow), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int nb);
    num_blocks  = 16'(nb);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_uf = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_dct_start", {31'd0, dct_start}, 32'd1);
    chk("start_err_uf_clr", {31'd0, err_underflow}, 32'd0);
    chk("start_err_to_clr", {31'd0, err_timeout}, 32'd0);
  endtask

  // Push 'count' samples of a frame whose full size is 'full'.
  task automatic feed(input int count, input int full, input int uf_at, input bit poke);
    int acc = 0;
    int cyc = 0;
    int ufc = 0;
    while (acc < count && cyc < 4 * count + 100) begin
      if (acc == uf_at && ufc < 3) begin
        src_valid = 1'b0; dct_reading = 1'b1; ufc++; m_uf = 1'b1;
      end else begin
        src_valid = 1'b1; dct_reading = ($urandom_range(0, 3) != 0);
      end
      src_data = $urandom;
      if (poke && cyc == 5) begin
        frame_start = 1'b1; num_blocks = 16'd0;
      end
      #1;
      chk("src_ready", {31'd0, src_ready}, {31'd0, dct_reading});
      if (src_valid && dct_reading) begin
        m_din = src_data;
        acc++;
      end
      tick();
      frame_start = 1'b0;
      cyc++;
      chk("dct_din", dct_din, m_din);
      chk("dct_start", {31'd0, dct_start}, {31'd0, acc < full});
      chk("err_underflow", {31'd0, err_underflow}, {31'd0, m_uf});
      chk("frame_done_feed", {31'd0, frame_done}, 32'd0);
    end
    if (acc < count) chk("feed_budget", 32'(acc), 32'(count));
    src_valid = 1'b0;
    dct_reading = 1'b0;
  endtask

  task automatic drain(input int nb, input int first_len);
    int fd = 0;
    int len;
    for (int b = 0; b < nb; b++) begin
      len = (b == 0) ? first_len : 64;
      for (int k = 0; k < len; k++) begin
        idct_done = 1'b1;
        idct_dout = $urandom;
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, k < 64});
        if (k < 64) chk("out_data", {24'd0, out_data}, (idct_dout >> 10) & 32'hFF);
        tick();
        if (frame_done) fd++;
        if (b == nb - 1 && k == 63) chk("frame_done_at_end", {31'd0, frame_done}, 32'd1);
      end
      idct_done = 1'b0;
      repeat (2) begin
        tick();
        if (frame_done) fd++;
      end
    end
    chk("frame_done_count", 32'(fd), 32'd1);
    chk("drain_idle", {31'd0, busy}, 32'd0);
    chk("drain_no_uf", {31'd0, err_underflow}, {31'd0, m_uf});
    chk("drain_no_to", {31'd0, err_timeout}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0; frame_start = 1'b0; num_blocks = 16'd0; src_valid = 1'b0;
    src_data = 32'd0; dct_reading = 1'b0; dct_done = 1'b0; dct_dout = 32'd0;
    idct_done = 1'b0; idct_dout = 32'd0; m_din = 32'd0; m_uf = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dct_start", {31'd0, dct_start}, 32'd0);
    chk("rst_dct_din", dct_din, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_errs", {30'd0, err_underflow, err_timeout}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Combinational datapath slices.
    tbl[0] = '{32'h8004_0000, 32'h0003_FC00, 32'hFFFF_E001, 8'hFF};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0400, 32'h0000_1FFF, 8'h01};
    for (int i = 2; i < 6; i++) begin
      tbl[i].dd = $urandom;
      tbl[i].id = $urandom;
      tbl[i].exp_din = 32'($signed(tbl[i].dd) >>> 18);
      tbl[i].exp_od  = 8'((tbl[i].id / 1024) % 256);
    end
    for (int i = 0; i < 6; i++) begin
      dct_dout = tbl[i].dd; idct_dout = tbl[i].id; dct_done = i[0];
      #1;
      chk("idct_din", idct_din, tbl[i].exp_din);
      chk("out_data_map", {24'd0, out_data}, {24'd0, tbl[i].exp_od});
      chk("idct_start", {31'd0, idct_start}, {31'd0, i[0]});
    end
    dct_done = 1'b0; dct_dout = 32'd0; idct_dout = 32'd0;

    // Empty frame.
    num_blocks = 16'd0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("zero_frame_done", {31'd0, frame_done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("zero_frame_done_off", {31'd0, frame_done}, 32'd0);
    chk("zero_busy2", {31'd0, busy}, 32'd0);

    // One block, with a stray frame_start while busy.
    start_frame(1);
    feed(64, 64, -1, 1'b1);
    drain(1, 64);

    // idct window in IDLE is passed through.
    idct_done = 1'b1; #1;
    chk("idle_out_valid", {31'd0, out_valid}, 32'd1);
    tick(); idct_done = 1'b0; tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Two blocks, underflow after 10 samples, overlong first window.
    start_frame(2);
    feed(128, 128, 10, 1'b0);
    drain(2, 70);

    // Drain watchdog.
    start_frame(1);
    feed(64, 64, -1, 1'b0);
    n = 0;
    while (!err_timeout && n < 20000) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd16384);
    chk("timeout_frame_done", {31'd0, frame_done}, 32'd1);
    tick();
    chk("timeout_idle", {31'd0, busy}, 32'd0);
    chk("timeout_fd_off", {31'd0, frame_done}, 32'd0);
    chk("timeout_sticky", {31'd0, err_timeout}, 32'd1);

    // Reset mid-FEED.
    start_frame(4);
    feed(100, 256, 40, 1'b0);
    dct_reading = 1'b1; src_valid = 1'b1; idct_done = 1'b1;
    #3 reset = 1'b0;
    #1;
    m_din = 32'd0; m_uf = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_src_ready", {31'd0, src_ready}, 32'd0);
    chk("mid_rst_dct_start", {31'd0, dct_start}, 32'd0);
    chk("mid_rst_dct_din", dct_din, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_fd_errs", {29'd0, frame_done, err_underflow, err_timeout}, 32'd0);
    tick();
    reset = 1'b1; dct_reading = 1'b0; src_valid = 1'b0; idct_done = 1'b0;
    n = 0;
    repeat (3) begin
      tick();
      if (frame_done || busy) n++;
    end
    chk("mid_rst_no_done", 32'(n), 32'd0);
    start_frame(1);
    feed(64, 64, -1, 1'b0);
    drain(1, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
